// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the load/store unit: memop encodings, FSM states,
// bus widths and the access-legality rule.
package lsu_mem_port_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_t;

  // Unknown size, misaligned halfword/word, or a load and store at once.
  function automatic logic lsu_is_illegal(input logic [2:0] op,
                                          input logic [1:0] off,
                                          input logic       wr,
                                          input logic       rd);
    logic bad;
    bad = 1'b0;
    case (op)
      MEM_B, MEM_BU: bad = 1'b0;
      MEM_H, MEM_HU: bad = off[0];
      MEM_W:         bad = (off != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad | (wr & rd);
  endfunction

endpackage

// File: rtl/lsu_mem_port_align.sv
// Byte-lane steering: store byte enables and replicated write data, plus
// load lane extraction with sign/zero extension.
module lsu_align
  import lsu_mem_port_pkg::*;
(
  input  logic [2:0]         memop_i,
  input  logic [1:0]         off_i,
  input  logic [BUS_DW-1:0]  wdata_i,
  input  logic [BUS_DW-1:0]  rdata_i,
  output logic [BUS_BEW-1:0] be_o,
  output logic [BUS_DW-1:0]  wdata_o,
  output logic [BUS_DW-1:0]  rdata_o
);

  logic [BUS_DW-1:0] lane_s;

  assign lane_s = rdata_i >> {off_i, 3'b000};

  // Lane selection per access size
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    rdata_o = 32'h0000_0000;
    case (memop_i)
      MEM_B, MEM_BU: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        if (memop_i == MEM_B) begin
          rdata_o = {{24{lane_s[7]}}, lane_s[7:0]};
        end else begin
          rdata_o = {24'h00_0000, lane_s[7:0]};
        end
      end
      MEM_H, MEM_HU: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        if (memop_i == MEM_H) begin
          rdata_o = {{16{lane_s[15]}}, lane_s[15:0]};
        end else begin
          rdata_o = {16'h0000, lane_s[15:0]};
        end
      end
      MEM_W: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = lane_s;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit: turns one decoded load/store into a single valid/ready
// bus transaction and stalls the core until it completes or faults.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               memwr_i,
  input  logic               memtoreg_i,
  input  logic [2:0]         memop_i,
  input  logic [BUS_AW-1:0]  addr_i,
  input  logic [BUS_DW-1:0]  wdata_i,
  output logic               stall_o,
  output logic               done_o,
  output logic               fault_o,
  output logic [BUS_DW-1:0]  rdata_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [BUS_AW-1:0]  bus_addr_o,
  output logic [BUS_BEW-1:0] bus_be_o,
  output logic [BUS_DW-1:0]  bus_wdata_o,
  input  logic               bus_gnt_i,
  input  logic               bus_rvalid_i,
  input  logic [BUS_DW-1:0]  bus_rdata_i
);

  lsu_state_t         state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic [2:0]         op_q, op_d;
  logic [1:0]         off_q, off_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic [BUS_DW-1:0]  rdata_q, rdata_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [BUS_AW-1:0]  bus_addr_q, bus_addr_d;
  logic [BUS_BEW-1:0] bus_be_q, bus_be_d;
  logic [BUS_DW-1:0]  bus_wdata_q, bus_wdata_d;

  logic               access_s;
  logic               illegal_s;
  logic               tmo_hit_s;
  logic [2:0]         al_op_s;
  logic [1:0]         al_off_s;
  logic [BUS_BEW-1:0] al_be_s;
  logic [BUS_DW-1:0]  al_wdata_s;
  logic [BUS_DW-1:0]  al_rdata_s;

  assign access_s  = en_i & (memwr_i | memtoreg_i);
  assign illegal_s = lsu_is_illegal(memop_i, addr_i[1:0], memwr_i, memtoreg_i);
  assign tmo_hit_s = (TIMEOUT != 16'd0) && (timer_q == (TIMEOUT - 16'd1));

  // Aligner sees the live request in IDLE and the latched one afterwards
  always_comb begin
    if (state_q == ST_IDLE) begin
      al_op_s  = memop_i;
      al_off_s = addr_i[1:0];
    end else begin
      al_op_s  = op_q;
      al_off_s = off_q;
    end
  end

  lsu_align u_align (
    .memop_i (al_op_s),
    .off_i   (al_off_s),
    .wdata_i (wdata_i),
    .rdata_i (bus_rdata_i),
    .be_o    (al_be_s),
    .wdata_o (al_wdata_s),
    .rdata_o (al_rdata_s)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    op_d        = op_q;
    off_d       = off_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    rdata_d     = 32'h0000_0000;
    bus_req_d   = 1'b0;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (access_s && illegal_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else if (access_s) begin
          state_d     = ST_REQ;
          timer_d     = 16'd0;
          op_d        = memop_i;
          off_d       = addr_i[1:0];
          bus_req_d   = 1'b1;
          bus_we_d    = memwr_i;
          bus_addr_d  = {addr_i[31:2], 2'b00};
          bus_be_d    = al_be_s;
          bus_wdata_d = memwr_i ? al_wdata_s : 32'h0000_0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_gnt_i && bus_we_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (bus_gnt_i) begin
          state_d = ST_WAIT;
          timer_d = 16'd0;
        end else if (tmo_hit_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          timer_d   = timer_q + 16'd1;
          bus_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid_i) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          rdata_d = al_rdata_s;
        end else if (tmo_hit_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_DONE: begin
        // Core advances on this edge; a still-high en is not a new request.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= 16'd0;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      op_q        <= op_d;
      off_q       <= off_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign stall_o     = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                       ((state_q == ST_IDLE) && access_s);
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign rdata_o     = rdata_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule
